// File: rtl/rgb_sinp_word_if.sv
// FIFO write-side bus of the WS2812b word decoder: write strobe/data,
// full back-pressure and the two status flags.
interface rgb_sinp_word_if;
  logic        in_wr_fifo_full;
  logic        out_wr_fifo_en;
  logic [31:0] out_wr_fifo_data;
  logic        out_overflow;
  logic        out_frame_err;

  modport master (
    input  in_wr_fifo_full,
    output out_wr_fifo_en,
    output out_wr_fifo_data,
    output out_overflow,
    output out_frame_err
  );

  modport slave (
    output in_wr_fifo_full,
    input  out_wr_fifo_en,
    input  out_wr_fifo_data,
    input  out_overflow,
    input  out_frame_err
  );
endinterface

// File: rtl/rgb_sinp_word.sv
// WS2812b serial line decoder: measures high-pulse widths on the
// synchronized line, assembles 24-bit GRB words and writes them (or a
// stream-reset marker after a long low period) into a FIFO.
module rgb_sinp_word #(
  parameter int STREAM_RESET_CLKS = 4800,
  parameter int MIN_HIGH_CLKS     = 8,
  parameter int BIT1_THRESH_CLKS  = 58,
  parameter int MAX_HIGH_CLKS     = 120
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_sig,
  rgb_sinp_word_if.master bus
);

  localparam int CNT_MAX = (STREAM_RESET_CLKS > MAX_HIGH_CLKS) ? STREAM_RESET_CLKS : MAX_HIGH_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Thresholds expressed as "count before this clock" so that the
  // comparisons fire on the clock where the count reaches the limit.
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] SR_M1    = CNT_W'(STREAM_RESET_CLKS - 1);
  localparam logic [CNT_W-1:0] MAXH_M1  = CNT_W'(MAX_HIGH_CLKS - 1);
  localparam logic [CNT_W-1:0] MINH     = CNT_W'(MIN_HIGH_CLKS);
  localparam logic [CNT_W-1:0] BIT1     = CNT_W'(BIT1_THRESH_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [31:0] RESET_WORD = 32'hC000_0000;

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  // Counter increment that sticks at its top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_LIM) return v;
    return v + 1'b1;
  endfunction

  logic sig_meta;
  logic sig_s;
  logic sig_d;
  logic rise;
  logic fall;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       bits, bits_n;
  logic [22:0]      shift, shift_n;
  logic             wr_en, wr_en_n;
  logic [31:0]      wr_data, wr_data_n;
  logic             ovf, ovf_n;
  logic             ferr, ferr_n;

  logic             bit_val;
  logic [23:0]      shifted;
  logic             do_write;
  logic [31:0]      word;

  assign rise = sig_s & ~sig_d;
  assign fall = ~sig_s & sig_d;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_meta <= 1'b0;
      sig_s    <= 1'b0;
      sig_d    <= 1'b0;
    end else begin
      sig_meta <= in_sig;
      sig_s    <= sig_meta;
      sig_d    <= sig_s;
    end
  end

  // State, counters, shift register and registered FIFO-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_SYNC;
      cnt     <= '0;
      bits    <= '0;
      shift   <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      ovf     <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bits    <= bits_n;
      shift   <= shift_n;
      wr_en   <= wr_en_n;
      wr_data <= wr_data_n;
      ovf     <= ovf_n;
      ferr    <= ferr_n;
    end
  end

  // Next-state logic: pulse measurement, bit decode, word assembly and
  // the write/drop decision against the FIFO full flag.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bits_n    = bits;
    shift_n   = shift;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data;
    ovf_n     = ovf;
    ferr_n    = 1'b0;
    bit_val   = (cnt >= BIT1);
    shifted   = {shift, bit_val};
    do_write  = 1'b0;
    word      = '0;

    case (state)
      S_SYNC: begin
        // Nothing is decoded until a full stream-reset low period is seen.
        if (sig_s) begin
          cnt_n = '0;
        end else if (cnt >= SR_M1) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = sat_inc(cnt);
        end
      end

      S_IDLE: begin
        if (rise) begin
          state_n = S_HIGH;
          cnt_n   = CNT_ONE;
        end
      end

      S_HIGH: begin
        if (sig_s) begin
          if (cnt >= MAXH_M1) begin
            // Stuck-high line: drop everything and resynchronize.
            ferr_n  = 1'b1;
            shift_n = '0;
            bits_n  = '0;
            state_n = S_SYNC;
            cnt_n   = '0;
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end else if (fall) begin
          state_n = S_LOW;
          cnt_n   = CNT_ONE;
          if (cnt >= MINH) begin
            if (bits == 5'd23) begin
              do_write = 1'b1;
              word     = {8'h80, shifted};
              shift_n  = '0;
              bits_n   = '0;
            end else begin
              shift_n = shifted[22:0];
              bits_n  = bits + 1'b1;
            end
          end
        end
      end

      S_LOW: begin
        if (rise) begin
          state_n = S_HIGH;
          cnt_n   = CNT_ONE;
        end else if (cnt >= SR_M1) begin
          // A partial word cannot survive a stream reset; flag it.
          do_write = 1'b1;
          word     = RESET_WORD;
          ferr_n   = (bits != 5'd0);
          bits_n   = '0;
          shift_n  = '0;
          state_n  = S_IDLE;
          cnt_n    = '0;
        end else begin
          cnt_n = sat_inc(cnt);
        end
      end

      default: begin
        state_n = S_SYNC;
        cnt_n   = '0;
      end
    endcase

    if (do_write) begin
      if (bus.in_wr_fifo_full) begin
        ovf_n = 1'b1;
      end else begin
        wr_en_n   = 1'b1;
        wr_data_n = word;
      end
    end
  end

  assign bus.out_wr_fifo_en   = wr_en;
  assign bus.out_wr_fifo_data = wr_data;
  assign bus.out_overflow     = ovf;
  assign bus.out_frame_err    = ferr;

endmodule

// File: tb/tb_rgb_sinp_word.sv
// Directed bench for rgb_sinp_word: drives WS2812b waveforms, keeps a
// queue of expected FIFO-side events and compares them as they appear.
module tb_rgb_sinp_word;

  typedef struct {
    logic        en;
    logic [31:0] data;
    logic        ferr;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic in_sig;

  rgb_sinp_word_if bus ();

  rgb_sinp_word dut (
    .clk    (clk),
    .rst    (rst),
    .in_sig (in_sig),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  n_vec    = 0;
  int  n_miss   = 0;
  int  cyc      = 0;
  int  ferr_cyc = -1;
  int  t0       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic en, input logic [31:0] data, input logic ferr);
    ev_t e;
    e.en   = en;
    e.data = data;
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  // One clock; outputs are sampled on the falling edge and any write or
  // frame-error pulse is matched against the head of the queue.
  task automatic cycle();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (bus.out_wr_fifo_en === 1'b1 || bus.out_frame_err === 1'b1) begin
      if (bus.out_frame_err === 1'b1) ferr_cyc = cyc;
      check("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_en", {31'b0, bus.out_wr_fifo_en}, {31'b0, e.en});
        if (e.en) check("wr_data", bus.out_wr_fifo_data, e.data);
        check("frame_err", {31'b0, bus.out_frame_err}, {31'b0, e.ferr});
      end
    end
  endtask

  task automatic hold_low(input int n);
    in_sig = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send_bit(input logic b);
    int h;
    h = b ? 77 : 38;
    in_sig = 1'b1;
    repeat (h) cycle();
    in_sig = 1'b0;
    repeat (120 - h) cycle();
  endtask

  // Sends the top n bits of w, MSB first; a 5-clock glitch follows bit
  // index glitch_after (counted from 0) when it is non-negative.
  task automatic send_bits(input logic [23:0] w, input int n, input int glitch_after);
    for (int i = 0; i < n; i++) begin
      send_bit(w[23 - i]);
      if (i == glitch_after) begin
        in_sig = 1'b1;
        repeat (5) cycle();
        in_sig = 1'b0;
        repeat (40) cycle();
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},   {31'b0, bus.out_wr_fifo_en}, 32'd0);
    check({tag, "_data"}, bus.out_wr_fifo_data,        32'd0);
    check({tag, "_ovf"},  {31'b0, bus.out_overflow},   32'd0);
    check({tag, "_ferr"}, {31'b0, bus.out_frame_err},  32'd0);
  endtask

  initial begin
    in_sig = 1'b0;
    bus.in_wr_fifo_full = 1'b0;
    rst = 1'b1;
    repeat (3) cycle();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Bits sent before the line has been low long enough are ignored.
    send_bits(24'hA5A5A5, 24, -1);
    hold_low(4810);
    check("pending_presync", 32'(exp_q.size()), 32'd0);

    // First full word, then exactly one stream-reset word.
    push(1'b1, 32'h8012_3456, 1'b0);
    send_bits(24'h123456, 24, -1);
    check("pending_word1", 32'(exp_q.size()), 32'd0);
    push(1'b1, 32'hC000_0000, 1'b0);
    hold_low(4810);
    check("pending_sr1", 32'(exp_q.size()), 32'd0);
    hold_low(10000);
    check("pending_long_low", 32'(exp_q.size()), 32'd0);

    // Partial word cut short by a stream reset.
    push(1'b1, 32'hC000_0000, 1'b1);
    send_bits(24'hB3C000, 10, -1);
    hold_low(4810);
    check("pending_partial", 32'(exp_q.size()), 32'd0);

    // Glitch between bits must not shift a bit in.
    push(1'b1, 32'h80FF_00AA, 1'b0);
    push(1'b1, 32'hC000_0000, 1'b0);
    send_bits(24'hFF00AA, 24, 8);
    hold_low(4810);
    check("pending_glitch", 32'(exp_q.size()), 32'd0);

    // Over-long high pulse: frame error on its 120th synchronized clock
    // (two synchronizer clocks after the line rises), then silent resync.
    ferr_cyc = -1;
    push(1'b0, 32'd0, 1'b1);
    t0 = cyc;
    in_sig = 1'b1;
    repeat (130) cycle();
    check("ferr_timing", 32'(ferr_cyc - t0), 32'd122);
    hold_low(4810);
    check("pending_framing", 32'(exp_q.size()), 32'd0);

    // Word completed while the FIFO is full is dropped and flagged.
    check("ovf_before", {31'b0, bus.out_overflow}, 32'd0);
    bus.in_wr_fifo_full = 1'b1;
    send_bits(24'h654321, 24, -1);
    check("ovf_set", {31'b0, bus.out_overflow}, 32'd1);
    check("pending_dropped", 32'(exp_q.size()), 32'd0);
    bus.in_wr_fifo_full = 1'b0;
    push(1'b1, 32'h80AB_CDEF, 1'b0);
    push(1'b1, 32'hC000_0000, 1'b0);
    send_bits(24'hABCDEF, 24, -1);
    hold_low(4810);
    check("pending_after_full", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", {31'b0, bus.out_overflow}, 32'd1);

    rst = 1'b1;
    repeat (2) cycle();
    check_reset_outputs("reset_end");
    rst = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
